// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// The status register reports busy/full/overrun/count; overrun is sticky until written with bit 2 set.
module csr_uart_tx #(
    parameter logic [11:0] ADDR_DATA = 12'h7C0,
    parameter logic [11:0] ADDR_STAT = 12'h7C1,
    parameter int          BAUD_DIV  = 434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] cadr_i,
    input  logic        coe_i,
    input  logic        cwe_i,
    input  logic [63:0] cdat_i,
    output logic [63:0] cdat_o,
    output logic        cvalid_o,
    output logic        txd_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  mem_q [4];
    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  count_q;
    logic        overrun_q;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        txd_q, txd_d;
    logic        pop;

    logic hit_data, hit_stat, busy, full, baud_done;
    logic push_req, push_ok, ovr_clr;
    logic unused_cdat;

    assign unused_cdat = ^cdat_i[63:8];

    assign hit_data  = (cadr_i == ADDR_DATA);
    assign hit_stat  = (cadr_i == ADDR_STAT);
    assign cvalid_o  = (hit_data | hit_stat) & (coe_i | cwe_i);
    assign busy      = (state_q != IDLE) | (count_q != 3'd0);
    assign full      = (count_q == 3'd4);
    assign baud_done = (baud_q == 16'd0);
    assign push_req  = cwe_i & hit_data;
    // A full FIFO still accepts a byte when the shifter drains one at the same edge.
    assign push_ok   = push_req & (~full | pop);
    assign ovr_clr   = cwe_i & hit_stat & cdat_i[2];
    assign txd_o     = txd_q;

    always_comb begin
        cdat_o = '0;
        if (coe_i && hit_stat) begin
            cdat_o[5:0] = {count_q, overrun_q, full, busy};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    state_d = START;
                    baud_d  = RELOAD;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next frame when more bytes are queued.
                    if (count_q != 3'd0) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rptr_q];
                        state_d = START;
                        baud_d  = RELOAD;
                    end else begin
                        state_d = IDLE;
                        baud_d  = 16'd0;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
            end
        endcase

        txd_d = 1'b1;
        if (state_d == START) begin
            txd_d = 1'b0;
        end else if (state_d == DATA) begin
            txd_d = shreg_d[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            count_q   <= 3'd0;
            overrun_q <= 1'b0;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            if (push_ok) begin
                wptr_q <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push_ok) begin
            mem_q[wptr_q] <= cdat_i[7:0];
        end
    end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx: CSR decode vectors, directed frame sequences and random traffic
// checked each cycle against a frame-timeline model of the serial line.
module tb_csr_uart_tx;

    localparam int          BD     = 4;
    localparam logic [11:0] A_DATA = 12'h7C0;
    localparam logic [11:0] A_STAT = 12'h7C1;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [11:0] cadr_i;
    logic        coe_i;
    logic        cwe_i;
    logic [63:0] cdat_i;
    logic [63:0] cdat_o;
    logic        cvalid_o;
    logic        txd_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: queued bytes, and the frame currently on the line as a 10-bit pattern plus a time index.
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_pos;
    logic [9:0] m_frame;
    bit         m_ovr;

    typedef struct {
        logic [11:0] cadr;
        logic        coe;
        logic        cwe;
        logic [63:0] cdat;
        logic        exp_valid;
        logic [63:0] exp_cdat;
    } vec_t;

    vec_t vt[7];

    csr_uart_tx #(.ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT), .BAUD_DIV(BD)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .cadr_i  (cadr_i),
        .coe_i   (coe_i),
        .cwe_i   (cwe_i),
        .cdat_i  (cdat_i),
        .cdat_o  (cdat_o),
        .cvalid_o(cvalid_o),
        .txd_o   (txd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        return m_active ? m_frame[m_pos / BD] : 1'b1;
    endfunction

    function automatic logic [63:0] exp_stat();
        logic [63:0] s;
        int          sz;
        sz = m_q.size();
        s  = '0;
        s[0]   = m_active || (sz != 0);
        s[1]   = (sz == 4);
        s[2]   = m_ovr;
        s[5:3] = 3'(sz);
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int sz;
        bit popped;
        bit set_ovr;
        if (reset_i) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovr    = 0;
            return;
        end
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * BD) m_active = 0;
        end
        sz      = m_q.size();
        popped  = 0;
        set_ovr = 0;
        if (!m_active && sz > 0) begin
            m_frame  = {1'b1, m_q.pop_front(), 1'b0};
            m_active = 1;
            m_pos    = 0;
            popped   = 1;
        end
        if (cwe_i && cadr_i == A_DATA) begin
            if (sz < 4 || popped) m_q.push_back(cdat_i[7:0]);
            else begin
                m_ovr   = 1;
                set_ovr = 1;
            end
        end
        if (cwe_i && cadr_i == A_STAT && cdat_i[2] && !set_ovr) m_ovr = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        cwe_i = 1'b0;
        coe_i = 1'b0;
        check("txd", {63'd0, txd_o}, {63'd0, exp_txd()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_data(input logic [7:0] b);
        cadr_i = A_DATA;
        cwe_i  = 1'b1;
        cdat_i = {$urandom(), $urandom()};
        cdat_i[7:0] = b;
        step();
    endtask

    task automatic wr_stat(input logic [63:0] d);
        cadr_i = A_STAT;
        cwe_i  = 1'b1;
        cdat_i = d;
        step();
    endtask

    task automatic read_stat(input string name, output logic [63:0] v);
        cadr_i = A_STAT;
        coe_i  = 1'b1;
        cwe_i  = 1'b0;
        #1;
        v = cdat_o;
        check(name, cdat_o, exp_stat());
        check({name, "_valid"}, {63'd0, cvalid_o}, 64'd1);
        coe_i = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_active || m_q.size() != 0) && guard < 2000) begin
            step();
            guard++;
        end
        check("drain_timeout", 64'(guard >= 2000), 64'd0);
        idle(2);
    endtask

    initial begin
        logic [63:0] s;
        int          guard;

        reset_i = 1'b1;
        cadr_i  = '0;
        coe_i   = 1'b0;
        cwe_i   = 1'b0;
        cdat_i  = '0;
        m_active = 0;
        m_pos    = 0;
        m_ovr    = 0;
        m_frame  = '1;

        vt[0] = '{A_STAT, 1'b1, 1'b0, 64'd0, 1'b1, 64'd0};
        vt[1] = '{12'h7C2, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0};
        vt[2] = '{A_DATA, 1'b1, 1'b0, 64'd0, 1'b1, 64'd0};
        vt[3] = '{A_STAT, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0};
        vt[4] = '{A_DATA, 1'b0, 1'b1, 64'hFFFF_0000_0000_00AB, 1'b1, 64'd0};
        vt[5] = '{A_STAT, 1'b0, 1'b1, 64'h4, 1'b1, 64'd0};
        vt[6] = '{12'h000, 1'b1, 1'b1, 64'h12, 1'b0, 64'd0};

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_txd", {63'd0, txd_o}, 64'd1);
        read_stat("reset_stat", s);

        // Decode vectors applied while reset is held so CSR writes cannot disturb state.
        for (int i = 0; i < 7; i++) begin
            cadr_i = vt[i].cadr;
            coe_i  = vt[i].coe;
            cwe_i  = vt[i].cwe;
            cdat_i = vt[i].cdat;
            #1;
            check($sformatf("vec%0d_valid", i), {63'd0, cvalid_o}, {63'd0, vt[i].exp_valid});
            check($sformatf("vec%0d_cdat", i), cdat_o, vt[i].exp_cdat);
        end
        coe_i = 1'b0;
        cwe_i = 1'b0;

        wr_data(8'h77);
        reset_i = 1'b0;
        idle(3);
        read_stat("post_reset_stat", s);
        check("post_reset_stat_zero", s, 64'd0);

        // Single byte 0xA5 at idle.
        wr_data(8'hA5);
        idle(10 * BD + 3);
        read_stat("a5_stat", s);
        check("a5_stat_zero", s, 64'd0);

        // Five back-to-back writes: the first pop makes room for the fifth.
        for (int i = 1; i <= 5; i++) wr_data(8'(i));
        read_stat("b2b_stat", s);
        check("b2b_no_overrun", {63'd0, s[2]}, 64'd0);
        drain();

        // Fill while busy, then overflow and clear.
        wr_data(8'h11);
        idle(2);
        wr_data(8'h22);
        wr_data(8'h33);
        wr_data(8'h44);
        wr_data(8'h55);
        read_stat("full_stat", s);
        check("full_stat_23", s, 64'h23);
        wr_data(8'hFF);
        read_stat("ovr_stat", s);
        check("ovr_stat_27", s, 64'h27);
        wr_stat(64'h4);
        read_stat("ovr_clr_stat", s);
        check("ovr_cleared", {63'd0, s[2]}, 64'd0);
        drain();

        // Push at count 4 on the edge where the running frame ends and the head is popped.
        wr_data(8'h81);
        idle(2);
        for (int i = 0; i < 4; i++) wr_data(8'h90 + 8'(i));
        guard = 0;
        while (!(m_active && m_pos == 10 * BD - 1) && guard < 200) begin
            step();
            guard++;
        end
        check("pushpop_wait_timeout", 64'(guard >= 200), 64'd0);
        wr_data(8'hC3);
        read_stat("pushpop_stat", s);
        check("pushpop_count4", 64'(s[5:3]), 64'd4);
        check("pushpop_no_ovr", {63'd0, s[2]}, 64'd0);
        drain();

        // Reset during data bit 3 aborts the frame and discards the queue.
        wr_data(8'h5A);
        wr_data(8'h66);
        guard = 0;
        while (!(m_active && m_pos / BD == 4) && guard < 200) begin
            step();
            guard++;
        end
        check("bit3_wait_timeout", 64'(guard >= 200), 64'd0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("abort_txd", {63'd0, txd_o}, 64'd1);
        read_stat("abort_stat", s);
        check("abort_stat_zero", s, 64'd0);
        idle(12 * BD);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    wr_data(8'($urandom()));
                2:       wr_stat({$urandom(), $urandom()});
                3:       begin read_stat("rand_stat", s); step(); end
                default: step();
            endcase
        end
        drain();
        read_stat("final_stat", s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_uart_tx.md
CSR_UART_TX -- requirements
Module: csr_uart_tx

Interface
REQ-001 SHALL have parameter ADDR_DATA, default 12'h7C0, CSR address of the transmit-data register.
REQ-002 SHALL have parameter ADDR_STAT, default 12'h7C1, CSR address of the status register.
REQ-003 SHALL have parameter BAUD_DIV, default 434, clk_i cycles per serial bit (legal 2..65535).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cadr_i, input, 12, CSR address from CPU.
REQ-007 SHALL have port coe_i, input, 1, CSR read strobe.
REQ-008 SHALL have port cwe_i, input, 1, CSR write strobe.
REQ-009 SHALL have port cdat_i, input, 64, CSR write data.
REQ-010 SHALL have port cdat_o, output, 64, CSR read data.
REQ-011 SHALL have port cvalid_o, output, 1, CSR address claimed by this block.
REQ-012 SHALL have port txd_o, output, 1, serial transmit line, idle high.

Function
REQ-013 SHALL drive cvalid_o combinationally = (cadr_i==ADDR_DATA or cadr_i==ADDR_STAT) and (coe_i or cwe_i).
REQ-014 SHALL drive cdat_o combinationally; STAT read returns bit0 busy, bit1 full, bit2 overrun, bits[5:3] FIFO count 0..4, other bits 0; DATA read and unclaimed cycles return 0.
REQ-015 SHALL hold a 4-entry 8-bit FIFO; cwe_i to ADDR_DATA pushes cdat_i[7:0] at the clock edge.
REQ-016 SHALL accept a push when count<4, or when count==4 and a pop occurs in the same cycle (count stays 4).
REQ-017 SHALL drop a rejected push, leave FIFO contents unchanged, and set sticky overrun=1.
REQ-018 SHALL clear overrun on cwe_i to ADDR_STAT with cdat_i[2]=1; a same-cycle overrun set wins over the clear.
REQ-019 SHALL ignore cdat_i bits other than [7:0] (DATA) and [2] (STAT); coe_i SHALL have no side effects.
REQ-020 SHALL implement shifter states IDLE, START, DATA, STOP.
REQ-021 IDLE: when FIFO non-empty, SHALL pop the head into an 8-bit shift register and go to START at the same edge.
REQ-022 START: txd_o=0 for BAUD_DIV cycles, then DATA.
REQ-023 DATA: 8 bits LSB first, each held BAUD_DIV cycles; after bit 7 go to STOP.
REQ-024 STOP: txd_o=1 for BAUD_DIV cycles, then IDLE; if FIFO non-empty at the end of STOP, SHALL pop and go directly to START (no idle gap).
REQ-025 SHALL register txd_o; it is 1 in IDLE and STOP.
REQ-026 busy SHALL be 1 when state!=IDLE or count!=0; full SHALL be count==4.
REQ-027 Latency: a push at edge N into an empty, idle block SHALL make txd_o fall after edge N+1; one frame lasts 10*BAUD_DIV cycles.
REQ-028 Baud counter SHALL count BAUD_DIV-1 down to 0 per bit; it SHALL reload on every state or bit transition and SHALL never wrap silently.
REQ-029 FIFO pointers SHALL be 2-bit and wrap 3->0; count SHALL be 3-bit.

Reset
REQ-030 On reset_i=1 at an edge, the block SHALL set state IDLE, txd_o=1, FIFO empty (count 0, pointers 0), overrun=0, baud and bit counters 0.
REQ-031 Reset mid-frame SHALL abort the frame: txd_o=1 after that edge, queued bytes are discarded, and no partial frame resumes.
REQ-032 CSR strobes coincident with reset_i SHALL have no effect.

Verification (BAUD_DIV=4)
REQ-033 Write 8'hA5 to ADDR_DATA at idle -> txd_o low 4 cycles starting the cycle after the next edge, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; STAT reads 0 afterwards.
REQ-034 5 back-to-back writes 8'h01..8'h05 at idle -> first byte popped before write 5, so no overrun; frames arrive back-to-back with no idle gap; STAT bit2=0.
REQ-035 Fill FIFO while the shifter is busy, then write 8'hFF -> STAT=0x23 (count 4, full, busy), then overrun set (STAT=0x27), 8'hFF never transmitted; writing STAT with cdat_i=4 -> bit2 cleared.
REQ-036 Push and pop in the same cycle with count==4 -> push accepted, count stays 4, overrun stays 0.
REQ-037 Assert reset_i during DATA bit 3 -> txd_o=1 next cycle, STAT=0, line stays high with no resumed frame.
REQ-038 coe_i with cadr_i=12'h7C2 -> cvalid_o=0 and cdat_o=0; coe_i with cadr_i=ADDR_STAT -> cvalid_o=1 in the same cycle.
